// File: rtl/rom_fetch_unit.sv
// Instruction fetch front end for the 4 KiB boot ROM: issues word reads,
// buffers results in a 2-entry FIFO and turns illegal PCs into fault packets.
module rom_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] ROM_BASE = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        rom_ce,
  output logic        rom_oce,
  output logic [9:0]  rom_ad,
  input  logic [31:0] rom_dout,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  output logic        instr_fault
);

  typedef enum logic {ST_RUN, ST_HALT} state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] ROM_BYTES = 32'h0000_1000;

  state_t      state;
  logic [31:0] pc;
  logic        inflight;
  logic        inflight_fault;
  logic [31:0] inflight_pc;
  logic [9:0]  rom_ad_q;

  logic [31:0] fifo_data  [2];
  logic [31:0] fifo_pc    [2];
  logic        fifo_fault [2];
  logic        head;
  logic [1:0]  count;

  logic        pop;
  logic        go;
  logic        issue_legal;
  logic [31:0] issue_pc;
  logic [31:0] issue_off;
  logic [2:0]  occupancy;
  logic        wr_idx;
  logic        push;

  assign instr_valid = !reset && (count != 2'd0);
  assign pop         = instr_valid && instr_ready;

  // A redirect overrides the sequential pc and frees all buffering in the same cycle.
  assign issue_pc  = redirect_valid ? redirect_pc : pc;
  assign issue_off = issue_pc - ROM_BASE;

  // A pc below ROM_BASE wraps to a huge offset, so one compare covers both window edges.
  assign issue_legal = (issue_pc[1:0] == 2'b00) && (issue_off < ROM_BYTES);

  assign occupancy = {1'b0, count} + {2'b00, inflight};
  assign go = !reset &&
              (redirect_valid ||
               ((state == ST_RUN) && (occupancy <= ({2'b00, pop} + 3'd1))));

  assign rom_ce  = go && issue_legal;
  assign rom_oce = 1'b1;
  assign rom_ad  = rom_ce ? issue_off[11:2] : rom_ad_q;

  assign push   = inflight && !redirect_valid;
  assign wr_idx = head ^ count[0];

  assign instr_data  = instr_valid ? fifo_data[head]  : 32'h0000_0000;
  assign instr_pc    = instr_valid ? fifo_pc[head]    : 32'h0000_0000;
  assign instr_fault = instr_valid ? fifo_fault[head] : 1'b0;

  // An illegal pc travels down the read pipeline as a fault slot, so fault
  // packets keep the same issue-to-valid latency and FIFO ordering as reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_RUN;
      pc             <= RESET_PC;
      inflight       <= 1'b0;
      inflight_fault <= 1'b0;
      inflight_pc    <= 32'h0000_0000;
      rom_ad_q       <= 10'd0;
      head           <= 1'b0;
      count          <= 2'd0;
    end else begin
      if (rom_ce) begin
        rom_ad_q <= issue_off[11:2];
      end

      if (go) begin
        inflight       <= 1'b1;
        inflight_pc    <= issue_pc;
        inflight_fault <= !issue_legal;
        if (issue_legal) begin
          pc    <= issue_pc + 32'd4;
          state <= ST_RUN;
        end else begin
          pc    <= issue_pc;
          state <= ST_HALT;
        end
      end else begin
        inflight <= 1'b0;
      end

      if (redirect_valid) begin
        head  <= 1'b0;
        count <= 2'd0;
      end else begin
        if (push) begin
          fifo_data[wr_idx]  <= inflight_fault ? NOP_INSTR : rom_dout;
          fifo_pc[wr_idx]    <= inflight_pc;
          fifo_fault[wr_idx] <= inflight_fault;
        end
        if (pop) begin
          head <= ~head;
        end
        count <= count + {1'b0, push} - {1'b0, pop};
      end
    end
  end

endmodule

// File: tb/tb_rom_fetch_unit.sv
// Self-checking bench for rom_fetch_unit: directed vector table, hand-written
// boundary/stall sequences, then random traffic against a stream-level model.
module tb_rom_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        rom_ce;
  logic        rom_oce;
  logic [9:0]  rom_ad;
  logic [31:0] rom_dout;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        instr_fault;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        rst;
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        ce;
    logic [9:0]  ad;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] data;
    logic        fault;
  } vec_t;

  vec_t vecs[$];

  logic [31:0] got_pc[$];
  logic [31:0] got_data[$];
  logic        got_fault[$];

  logic        r_rst, r_rv, r_rdy;
  logic [31:0] r_rpc;
  logic [31:0] m_exp_pc;
  logic [31:0] m_restart_pc;
  logic [31:0] exp_pc;
  bit          m_halted;
  bit          m_in_reset;
  bit          m_prev_pop;
  int          m_since;

  rom_fetch_unit #(
    .RESET_PC(RESET_PC),
    .ROM_BASE(32'h0000_0000)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .rom_ce         (rom_ce),
    .rom_oce        (rom_oce),
    .rom_ad         (rom_ad),
    .rom_dout       (rom_dout),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .instr_fault    (instr_fault)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: word i holds 0x1000_0000 + i, data one cycle after rom_ce.
  always @(posedge clk) begin
    if (rom_ce) rom_dout <= 32'h1000_0000 + {22'd0, rom_ad};
  end

  function automatic bit legalPc(input logic [31:0] pc);
    return (pc[1:0] == 2'b00) && (pc < 32'h0000_1000);
  endfunction

  function automatic logic [31:0] expData(input logic [31:0] pc);
    return legalPc(pc) ? (32'h1000_0000 + (pc >> 2)) : 32'h0000_0013;
  endfunction

  function automatic logic [31:0] pickPc();
    case ($urandom_range(0, 7))
      0:       return 32'($urandom_range(0, 32'hFFF)) | 32'h1;
      1:       return 32'h0000_1000 + 32'($urandom_range(0, 255)) * 4;
      2:       return 32'h0000_0FE0 + 32'($urandom_range(0, 7)) * 4;
      default: return 32'($urandom_range(0, 1023)) * 4;
    endcase
  endfunction

  function automatic vec_t mk(input logic rst, input logic rv, input logic [31:0] rpc,
                              input logic rdy, input logic ce, input logic [9:0] ad,
                              input logic valid, input logic [31:0] pc,
                              input logic [31:0] data, input logic fault);
    vec_t v;
    v.rst = rst; v.rv = rv; v.rpc = rpc; v.rdy = rdy; v.ce = ce; v.ad = ad;
    v.valid = valid; v.pc = pc; v.data = data; v.fault = fault;
    return v;
  endfunction

  task automatic applyStimulus(input logic rst, input logic rv, input logic [31:0] rpc,
                               input logic rdy);
    @(negedge clk);
    reset          = rst;
    redirect_valid = rv;
    redirect_pc    = rpc;
    instr_ready    = rdy;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic recordPop();
    if (instr_valid && instr_ready) begin
      got_pc.push_back(instr_pc);
      got_data.push_back(instr_data);
      got_fault.push_back(instr_fault);
    end
  endtask

  initial begin
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);

    // rst rv rpc rdy | ce ad valid pc data fault
    vecs.push_back(mk(1,0,32'h0,  1, 0,10'h000, 0,32'h000,32'h0,        0));
    vecs.push_back(mk(1,0,32'h0,  1, 0,10'h000, 0,32'h000,32'h0,        0));
    vecs.push_back(mk(0,0,32'h0,  1, 1,10'h000, 0,32'h000,32'h0,        0));
    vecs.push_back(mk(0,0,32'h0,  1, 1,10'h001, 0,32'h000,32'h0,        0));
    vecs.push_back(mk(0,0,32'h0,  1, 1,10'h002, 1,32'h000,32'h1000_0000,0));
    vecs.push_back(mk(0,0,32'h0,  1, 1,10'h003, 1,32'h004,32'h1000_0001,0));
    vecs.push_back(mk(0,0,32'h0,  0, 0,10'h003, 1,32'h008,32'h1000_0002,0));
    vecs.push_back(mk(0,0,32'h0,  0, 0,10'h003, 1,32'h008,32'h1000_0002,0));
    vecs.push_back(mk(0,0,32'h0,  1, 1,10'h004, 1,32'h008,32'h1000_0002,0));
    vecs.push_back(mk(0,0,32'h0,  1, 1,10'h005, 1,32'h00C,32'h1000_0003,0));
    vecs.push_back(mk(0,0,32'h0,  1, 1,10'h006, 1,32'h010,32'h1000_0004,0));
    vecs.push_back(mk(0,1,32'h100,1, 1,10'h040, 1,32'h014,32'h1000_0005,0));
    vecs.push_back(mk(0,0,32'h0,  1, 1,10'h041, 0,32'h000,32'h0,        0));
    vecs.push_back(mk(0,0,32'h0,  1, 1,10'h042, 1,32'h100,32'h1000_0040,0));
    vecs.push_back(mk(0,1,32'h102,1, 0,10'h042, 1,32'h104,32'h1000_0041,0));
    vecs.push_back(mk(0,0,32'h0,  1, 0,10'h042, 0,32'h000,32'h0,        0));
    vecs.push_back(mk(0,0,32'h0,  1, 0,10'h042, 1,32'h102,32'h0000_0013,1));
    vecs.push_back(mk(0,0,32'h0,  1, 0,10'h042, 0,32'h000,32'h0,        0));
    vecs.push_back(mk(0,0,32'h0,  1, 0,10'h042, 0,32'h000,32'h0,        0));
    vecs.push_back(mk(0,1,32'h0,  1, 1,10'h000, 0,32'h000,32'h0,        0));
    vecs.push_back(mk(0,0,32'h0,  1, 1,10'h001, 0,32'h000,32'h0,        0));
    vecs.push_back(mk(0,0,32'h0,  1, 1,10'h002, 1,32'h000,32'h1000_0000,0));
    vecs.push_back(mk(0,0,32'h0,  0, 0,10'h002, 1,32'h004,32'h1000_0001,0));
    vecs.push_back(mk(0,0,32'h0,  0, 0,10'h002, 1,32'h004,32'h1000_0001,0));
    vecs.push_back(mk(1,0,32'h0,  0, 0,10'h002, 0,32'h000,32'h0,        0));
    vecs.push_back(mk(0,0,32'h0,  1, 1,10'h000, 0,32'h000,32'h0,        0));
    vecs.push_back(mk(0,0,32'h0,  1, 1,10'h001, 0,32'h000,32'h0,        0));
    vecs.push_back(mk(0,0,32'h0,  1, 1,10'h002, 1,32'h000,32'h1000_0000,0));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].rv, vecs[i].rpc, vecs[i].rdy);
      checkOutput($sformatf("vec%0d rom_ce", i), rom_ce, vecs[i].ce);
      checkOutput($sformatf("vec%0d rom_ad", i), rom_ad, vecs[i].ad);
      checkOutput($sformatf("vec%0d rom_oce", i), rom_oce, 1);
      checkOutput($sformatf("vec%0d valid", i), instr_valid, vecs[i].valid);
      if (vecs[i].valid || vecs[i].rst) begin
        checkOutput($sformatf("vec%0d pc", i), instr_pc, vecs[i].pc);
        checkOutput($sformatf("vec%0d data", i), instr_data, vecs[i].data);
        checkOutput($sformatf("vec%0d fault", i), instr_fault, vecs[i].fault);
      end
    end

    // End of the ROM window: last word, then a fault packet at 0x1000.
    applyStimulus(0, 1, 32'h0000_0FF0, 1);
    checkOutput("edge redirect rom_ad", rom_ad, 10'h3FC);
    got_pc.delete(); got_data.delete(); got_fault.delete();
    for (int c = 0; c < 9; c++) begin
      applyStimulus(0, 0, 32'h0, 1);
      recordPop();
    end
    checkOutput("edge rom_ce halted", rom_ce, 0);
    checkOutput("edge packet count", got_pc.size(), 5);
    for (int k = 0; k < 5 && k < got_pc.size(); k++) begin
      exp_pc = 32'h0000_0FF0 + 32'(k) * 4;
      checkOutput($sformatf("edge pkt%0d pc", k), got_pc[k], exp_pc);
      checkOutput($sformatf("edge pkt%0d data", k), got_data[k], expData(exp_pc));
      checkOutput($sformatf("edge pkt%0d fault", k), got_fault[k], !legalPc(exp_pc));
    end

    // Five-cycle decode stall mid-stream: head held, no reads, no gaps after.
    applyStimulus(0, 1, 32'h0000_0200, 1);
    got_pc.delete(); got_data.delete(); got_fault.delete();
    for (int c = 0; c < 4; c++) begin
      applyStimulus(0, 0, 32'h0, 1);
      recordPop();
    end
    exp_pc = 32'h0000_0200 + 32'(got_pc.size()) * 4;
    for (int c = 0; c < 5; c++) begin
      applyStimulus(0, 0, 32'h0, 0);
      checkOutput($sformatf("stall%0d valid", c), instr_valid, 1);
      checkOutput($sformatf("stall%0d pc", c), instr_pc, exp_pc);
      checkOutput($sformatf("stall%0d data", c), instr_data, expData(exp_pc));
      checkOutput($sformatf("stall%0d rom_ce", c), rom_ce, 0);
    end
    for (int c = 0; c < 6; c++) begin
      applyStimulus(0, 0, 32'h0, 1);
      recordPop();
    end
    checkOutput("stall packet count", got_pc.size(), 9);
    foreach (got_pc[k]) begin
      checkOutput($sformatf("stall seq%0d pc", k), got_pc[k], 32'h0000_0200 + 32'(k) * 4);
    end

    // Random traffic checked against an in-order pc stream model.
    m_exp_pc = RESET_PC; m_halted = 0; m_in_reset = 0; m_prev_pop = 0;
    m_since = 99; m_restart_pc = RESET_PC;
    for (int i = 0; i < 3000; i++) begin
      r_rst = (i == 0) || ($urandom_range(0, 199) == 0);
      r_rv  = !r_rst && ($urandom_range(0, 15) == 0);
      r_rpc = pickPc();
      r_rdy = ($urandom_range(0, 3) != 0);
      applyStimulus(r_rst, r_rv, r_rpc, r_rdy);
      if (r_rst) begin
        checkOutput("rand reset valid", instr_valid, 0);
        checkOutput("rand reset rom_ce", rom_ce, 0);
        m_in_reset = 1; m_exp_pc = RESET_PC; m_halted = 0;
        m_since = 99; m_prev_pop = 0;
      end else begin
        if (m_in_reset) begin
          m_in_reset = 0; m_since = 0; m_restart_pc = RESET_PC;
          checkOutput("rand release valid", instr_valid, 0);
          checkOutput("rand release rom_ce", rom_ce, legalPc(r_rv ? r_rpc : RESET_PC));
        end else if (m_since < 99) begin
          m_since++;
        end
        if (m_since == 1) checkOutput("rand restart bubble", instr_valid, 0);
        if (m_since == 2) begin
          checkOutput("rand restart valid", instr_valid, 1);
          checkOutput("rand restart pc", instr_pc, m_restart_pc);
        end
        if (m_prev_pop) checkOutput("rand sustain valid", instr_valid, 1);
        if (m_halted) begin
          checkOutput("rand halted valid", instr_valid, 0);
          if (!r_rv) checkOutput("rand halted rom_ce", rom_ce, 0);
        end else if (instr_valid) begin
          checkOutput("rand pc", instr_pc, m_exp_pc);
          checkOutput("rand data", instr_data, expData(m_exp_pc));
          checkOutput("rand fault", instr_fault, !legalPc(m_exp_pc));
        end
        m_prev_pop = 0;
        if (instr_valid && r_rdy && !m_halted) begin
          if (legalPc(m_exp_pc)) begin
            m_exp_pc = m_exp_pc + 4;
            m_prev_pop = 1;
          end else begin
            m_halted = 1;
          end
        end
        if (r_rv) begin
          m_exp_pc = r_rpc; m_halted = 0; m_since = 0;
          m_restart_pc = r_rpc; m_prev_pop = 0;
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
